// File: rtl/ins_fetcher_if.sv
// Fetch-side bus bundle: icache request/response, branch-predictor probe,
// instruction-queue push and ROB redirect.
interface ins_fetcher_if;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_ins;

    logic [31:0] pred_pc_cur;
    logic [31:0] pred_ins_cur;
    logic [31:0] pred_pc_next;
    logic        pred_jump;

    logic        iq_valid;
    logic [31:0] iq_ins;
    logic [31:0] iq_pc;
    logic        iq_pred_jump;
    logic        iq_full;

    logic        rob_flush;
    logic [31:0] rob_flush_pc;

    modport master (
        output icache_req_valid, icache_req_addr,
        input  icache_resp_valid, icache_resp_ins,
        output pred_pc_cur, pred_ins_cur,
        input  pred_pc_next, pred_jump,
        output iq_valid, iq_ins, iq_pc, iq_pred_jump,
        input  iq_full,
        input  rob_flush, rob_flush_pc
    );

    modport slave (
        input  icache_req_valid, icache_req_addr,
        output icache_resp_valid, icache_resp_ins,
        input  pred_pc_cur, pred_ins_cur,
        output pred_pc_next, pred_jump,
        input  iq_valid, iq_ins, iq_pc, iq_pred_jump,
        output iq_full,
        output rob_flush, rob_flush_pc
    );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetch unit: one outstanding icache request, predictor-driven next PC,
// ROB redirect with stale-response drain. Define JALR_STALL_EN to park after a JALR.
module ins_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic          clk,
    input logic          rst,
    input logic          rdy,
    ins_fetcher_if.master bus
);

`ifdef JALR_STALL_EN
    typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, ISSUE = 2'd2, WAIT_JALR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, ISSUE = 2'd2} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] ins_reg;
    logic [31:0] ins_nxt;
    logic [31:0] old_addr;
    logic [31:0] old_nxt;

`ifdef JALR_STALL_EN
    logic is_jalr;
    assign is_jalr = (ins_reg[6:0] == 7'b1100111);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ins_reg <= '0;
        end else if (rdy) begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            ins_reg <= ins_nxt;
        end
    end

    // Address of the stale request being drained; only meaningful in DRAIN.
    always_ff @(posedge clk) begin
        if (rdy) begin
            old_addr <= old_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ins_nxt   = ins_reg;
        old_nxt   = old_addr;
        case (state)
            FETCH: begin
                if (bus.icache_resp_valid) begin
                    if (bus.rob_flush) begin
                        pc_nxt = bus.rob_flush_pc;
                    end else begin
                        ins_nxt   = bus.icache_resp_ins;
                        state_nxt = ISSUE;
                    end
                end else if (bus.rob_flush) begin
                    old_nxt   = pc;
                    pc_nxt    = bus.rob_flush_pc;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.rob_flush) begin
                    pc_nxt = bus.rob_flush_pc;
                end
                if (bus.icache_resp_valid) begin
                    state_nxt = FETCH;
                end
            end
            ISSUE: begin
                if (bus.rob_flush) begin
                    pc_nxt    = bus.rob_flush_pc;
                    state_nxt = FETCH;
                end else if (!bus.iq_full) begin
                    pc_nxt    = bus.pred_pc_next;
                    state_nxt = FETCH;
`ifdef JALR_STALL_EN
                    if (is_jalr) begin
                        state_nxt = WAIT_JALR;
                    end
`endif
                end
            end
`ifdef JALR_STALL_EN
            WAIT_JALR: begin
                if (bus.rob_flush) begin
                    pc_nxt    = bus.rob_flush_pc;
                    state_nxt = FETCH;
                end
            end
`endif
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Outputs are forced quiet while rst is high so the reset cycle itself is clean.
    assign bus.icache_req_valid = !rst && ((state == FETCH) || (state == DRAIN));
    assign bus.icache_req_addr  = rst ? RESET_PC : ((state == DRAIN) ? old_addr : pc);
    assign bus.pred_pc_cur      = rst ? 32'h0 : pc;
    assign bus.pred_ins_cur     = rst ? 32'h0 : ins_reg;
    assign bus.iq_valid         = !rst && (state == ISSUE) && !bus.rob_flush;
    assign bus.iq_ins           = rst ? 32'h0 : ins_reg;
    assign bus.iq_pc            = rst ? 32'h0 : pc;
    assign bus.iq_pred_jump     = !rst && bus.pred_jump;

endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream (outstanding request, held entry, stall).
module tb_ins_fetcher;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef JALR_STALL_EN
    localparam bit JSTALL = 1'b1;
`else
    localparam bit JSTALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    ins_fetcher_if ifc();

    ins_fetcher #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs for directed mode
    bit          rand_mode = 1'b0;
    int          lat = 2;
    bit          rst_v = 1'b1, rdy_v = 1'b1, full_v = 1'b0, flush_v = 1'b0;
    logic [31:0] fpc_v = 32'h0;

    // Cache environment
    bit          c_busy = 1'b0;
    int          c_cnt = 0;
    logic [31:0] c_addr = 32'h0;
    bit          last_reqv = 1'b0;
    logic [31:0] last_reqa = 32'h0;

    // Reference model of the fetch stream
    logic [31:0] m_pc = 32'h0, m_oaddr = 32'h0, m_hins = 32'h0;
    bit          m_out = 1'b0, m_stale = 1'b0, m_hold = 1'b0, m_jst = 1'b0;
    int          m_xfers = 0;
    int          obs_xfers = 0;

    function automatic logic [31:0] ins_at(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0)  return 32'h00100093;
        if (a == 32'h8)  return 32'h00000063;
        if (a == 32'h10) return 32'h000080E7;
        if (a < 32'h1000) return {a[11:0], 20'h00013};
        h = a * 32'h9E3779B1;
        case (h[31:30])
            2'd0:    return {h[24:0], 7'b0010011};
            2'd1:    return {h[24:0], 7'b0110011};
            2'd2:    return {h[24:0], 7'b1100011};
            default: return {h[24:0], 7'b1100111};
        endcase
    endfunction

    function automatic logic pred_jump_f(input logic [31:0] ins);
        return ins[6:0] == 7'b1100011;
    endfunction

    function automatic logic [31:0] pred_next_f(input logic [31:0] pc, input logic [31:0] ins);
        return pred_jump_f(ins) ? pc + 32'h10 : pc + 32'h4;
    endfunction

    always_comb begin
        ifc.pred_jump    = pred_jump_f(ifc.pred_ins_cur);
        ifc.pred_pc_next = pred_next_f(ifc.pred_pc_cur, ifc.pred_ins_cur);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        if (rst) begin
            chk("rst_req_valid", ifc.icache_req_valid, 0);
            chk("rst_req_addr", ifc.icache_req_addr, RESET_PC);
            chk("rst_pred_pc", ifc.pred_pc_cur, 0);
            chk("rst_pred_ins", ifc.pred_ins_cur, 0);
            chk("rst_iq_valid", ifc.iq_valid, 0);
            chk("rst_iq_ins", ifc.iq_ins, 0);
            chk("rst_iq_pc", ifc.iq_pc, 0);
            chk("rst_iq_pj", ifc.iq_pred_jump, 0);
        end else begin
            chk("req_valid", ifc.icache_req_valid, m_out);
            if (m_out) chk("req_addr", ifc.icache_req_addr, m_oaddr);
            chk("pred_pc_cur", ifc.pred_pc_cur, m_pc);
            chk("iq_valid", ifc.iq_valid, m_hold && !ifc.rob_flush);
            if (m_hold) begin
                chk("iq_pc", ifc.iq_pc, m_pc);
                chk("iq_ins", ifc.iq_ins, m_hins);
                chk("pred_ins_cur", ifc.pred_ins_cur, m_hins);
                chk("iq_pred_jump", ifc.iq_pred_jump, pred_jump_f(m_hins));
            end
        end
    endtask

    task automatic step();
        int r;
        @(posedge clk);
        #1;
        // Model: advance by the inputs of the cycle just ended
        if (rst) begin
            m_pc = RESET_PC; m_oaddr = RESET_PC; m_out = 1'b1; m_stale = 1'b0;
            m_hold = 1'b0; m_jst = 1'b0; m_hins = 32'h0;
        end else if (rdy) begin
            if (ifc.rob_flush) begin
                m_hold = 1'b0; m_jst = 1'b0; m_pc = ifc.rob_flush_pc;
                if (m_out && !ifc.icache_resp_valid) m_stale = 1'b1;
                else begin m_out = 1'b1; m_stale = 1'b0; m_oaddr = m_pc; end
            end else if (m_out && ifc.icache_resp_valid) begin
                if (m_stale) begin m_stale = 1'b0; m_oaddr = m_pc; end
                else begin m_out = 1'b0; m_hold = 1'b1; m_hins = ins_at(m_oaddr); end
            end else if (m_hold && !ifc.iq_full) begin
                m_xfers++;
                m_hold = 1'b0;
                m_pc = pred_next_f(m_pc, m_hins);
                if (JSTALL && (m_hins[6:0] == 7'b1100111)) m_jst = 1'b1;
                else begin m_out = 1'b1; m_stale = 1'b0; m_oaddr = m_pc; end
            end
        end
        // Cache environment
        if (rst) begin
            c_busy = 1'b0;
            ifc.icache_resp_valid = 1'b0;
        end else if (rdy) begin
            if (c_busy) begin
                if (ifc.icache_resp_valid) c_busy = 1'b0;
                else c_cnt--;
            end else if (last_reqv) begin
                c_busy = 1'b1;
                c_cnt  = (rand_mode ? int'($urandom_range(1, 4)) : lat) - 1;
                c_addr = last_reqa;
            end
            ifc.icache_resp_valid = c_busy && (c_cnt == 0);
            ifc.icache_resp_ins   = ifc.icache_resp_valid ? ins_at(c_addr) : $urandom();
        end
        // New inputs
        if (rand_mode) begin
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            ifc.iq_full   = ($urandom_range(0, 2) == 0);
            ifc.rob_flush = ($urandom_range(0, 9) == 0);
            r = int'($urandom_range(0, 15));
            if (r == 0)      ifc.rob_flush_pc = 32'hFFFF_FFF8;
            else if (r == 1) ifc.rob_flush_pc = 32'($urandom_range(0, 63)) * 4;
            else             ifc.rob_flush_pc = 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
        end else begin
            rst = rst_v;
            rdy = rdy_v;
            ifc.iq_full      = full_v;
            ifc.rob_flush    = flush_v;
            ifc.rob_flush_pc = fpc_v;
        end
        @(negedge clk);
        compare();
        last_reqv = ifc.icache_req_valid;
        last_reqa = ifc.icache_req_addr;
        if (!rst && rdy && ifc.iq_valid && !ifc.iq_full) obs_xfers++;
    endtask

    task automatic wait_iq(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ifc.iq_valid && n < max);
        chk("wait_iq", ifc.iq_valid, 1);
    endtask

    initial begin
        logic [31:0] cap_pc, cap_ins;
        int x0;
        rst = 1'b1; rdy = 1'b1;
        ifc.iq_full = 1'b0; ifc.rob_flush = 1'b0; ifc.rob_flush_pc = 32'h0;
        ifc.icache_resp_valid = 1'b0; ifc.icache_resp_ins = 32'h0;

        // Reset, first fetch with latency 2
        rst_v = 1'b1; lat = 2;
        step(); step();
        rst_v = 1'b0;
        step();
        chk("t1_req_valid", ifc.icache_req_valid, 1);
        chk("t1_req_addr", ifc.icache_req_addr, 32'h0);
        step(); step(); step();
        chk("t1_iq_valid", ifc.iq_valid, 1);
        chk("t1_iq_pc", ifc.iq_pc, 32'h0);
        chk("t1_iq_ins", ifc.iq_ins, 32'h00100093);
        step();
        chk("t1_next_req", ifc.icache_req_addr, 32'h4);
        chk("t1_next_req_v", ifc.icache_req_valid, 1);

        // Predicted-taken branch at 0x8
        wait_iq(20);
        wait_iq(20);
        chk("t2_iq_pc", ifc.iq_pc, 32'h8);
        chk("t2_iq_pj", ifc.iq_pred_jump, 1);
        step();
        chk("t2_next_req", ifc.icache_req_addr, 32'h18);

        // Queue full for 5 cycles while holding an entry
        full_v = 1'b1;
        wait_iq(20);
        cap_pc = ifc.iq_pc; cap_ins = ifc.iq_ins;
        chk("t3_iq_pc", cap_pc, 32'h18);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold_valid", ifc.iq_valid, 1);
            chk("t3_hold_pc", ifc.iq_pc, cap_pc);
            chk("t3_hold_ins", ifc.iq_ins, cap_ins);
            chk("t3_no_req", ifc.icache_req_valid, 0);
        end
        full_v = 1'b0;
        x0 = obs_xfers;
        step();
        step();
        chk("t3_one_xfer", obs_xfers - x0, 1);
        chk("t3_next_req", ifc.icache_req_addr, 32'h1C);

        // Flush while in ISSUE
        full_v = 1'b1;
        wait_iq(20);
        full_v = 1'b0; flush_v = 1'b1; fpc_v = 32'h40;
        x0 = obs_xfers;
        step();
        chk("t5_iq_valid", ifc.iq_valid, 0);
        flush_v = 1'b0;
        step();
        chk("t5_req_addr", ifc.icache_req_addr, 32'h40);
        chk("t5_req_valid", ifc.icache_req_valid, 1);
        chk("t5_no_xfer", obs_xfers - x0, 0);

        // Flush one cycle after a request at 0x20, latency 3
        lat = 3;
        full_v = 1'b1;
        wait_iq(20);
        full_v = 1'b0; flush_v = 1'b1; fpc_v = 32'h20;
        step();
        flush_v = 1'b0;
        step();
        chk("t4_req_r0", ifc.icache_req_addr, 32'h20);
        flush_v = 1'b1; fpc_v = 32'h100;
        step();
        chk("t4_req_r1", ifc.icache_req_addr, 32'h20);
        flush_v = 1'b0;
        step();
        chk("t4_req_r2", ifc.icache_req_addr, 32'h20);
        step();
        chk("t4_req_r3", ifc.icache_req_addr, 32'h20);
        step();
        chk("t4_req_r4", ifc.icache_req_addr, 32'h100);
        chk("t4_req_r4_v", ifc.icache_req_valid, 1);
        wait_iq(20);
        chk("t4_first_pc", ifc.iq_pc, 32'h100);

        // JALR at 0x10
        lat = 2;
        full_v = 1'b1;
        wait_iq(20);
        full_v = 1'b0; flush_v = 1'b1; fpc_v = 32'h10;
        step();
        flush_v = 1'b0;
        wait_iq(20);
        chk("t6_iq_pc", ifc.iq_pc, 32'h10);
        chk("t6_iq_ins", ifc.iq_ins, 32'h000080E7);
`ifdef JALR_STALL_EN
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_stall_req", ifc.icache_req_valid, 0);
            chk("t6_stall_iq", ifc.iq_valid, 0);
        end
        flush_v = 1'b1; fpc_v = 32'h200;
        step();
        flush_v = 1'b0;
        step();
        chk("t6_req_addr", ifc.icache_req_addr, 32'h200);
        chk("t6_req_valid", ifc.icache_req_valid, 1);
`else
        step();
        chk("t6_req_addr", ifc.icache_req_addr, 32'h14);
        chk("t6_req_valid", ifc.icache_req_valid, 1);
`endif

        // Randomized run
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        rst_v = 1'b0; rdy_v = 1'b1; full_v = 1'b0; flush_v = 1'b0;
        step();
        chk("xfer_count", obs_xfers,
            m_xfers + ((!rst && rdy && m_hold && !ifc.iq_full && !ifc.rob_flush) ? 1 : 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ins_fetcher.md
# ins_fetcher

Instruction fetch unit that produces the fetch stream. It owns the PC, issues one instruction-cache request at a time, and presents each fetched word with its PC to the combinational branch predictor. It takes the predictor's next-PC as the following fetch address and pushes {instruction, PC, predicted-taken} into the instruction queue. It sits between the icache, the predictor, the instruction queue and the ROB, which redirects it on mispredict.

## Interface
- RESET_PC, 32'h0, fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; 0 freezes all state and ignores all inputs
- icache_req_valid  out  1  fetch request outstanding
- icache_req_addr  out  32  fetch address, stable while request outstanding
- icache_resp_valid  in  1  one-cycle pulse, instruction returned
- icache_resp_ins  in  32  returned instruction
- pred_pc_cur  out  32  PC of instruction held for issue
- pred_ins_cur  out  32  instruction held for issue
- pred_pc_next  in  32  predicted next PC, combinational from predictor
- pred_jump  in  1  predicted taken
- iq_valid  out  1  entry offered to instruction queue
- iq_ins  out  32  instruction
- iq_pc  out  32  its PC
- iq_pred_jump  out  1  predicted-taken flag
- iq_full  in  1  queue cannot accept
- rob_flush  in  1  redirect (mispredict / exception)
- rob_flush_pc  in  32  redirect target

## Operation
- Registers: pc (32), ins_reg (32), state.
- States:
  - FETCH: request at pc outstanding.
  - DRAIN: stale request outstanding; pc already holds the redirect target.
  - ISSUE: ins_reg held for enqueue.
  - WAIT_JALR: only with the macro defined.
- Outputs:
  - icache_req_valid = state∈{FETCH, DRAIN}.
  - icache_req_addr = pc in FETCH, old_addr register in DRAIN.
  - pred_pc_cur = pc; pred_ins_cur = ins_reg.
  - iq_valid = (state==ISSUE) && !rob_flush.
  - iq_ins = ins_reg; iq_pc = pc; iq_pred_jump = pred_jump.
- FETCH:
  - On icache_resp_valid: ins_reg <= icache_resp_ins, go to ISSUE.
  - On rob_flush without a response: old_addr <= pc, pc <= rob_flush_pc, go to DRAIN.
  - On rob_flush in the same cycle as a response: discard the response, pc <= rob_flush_pc, stay in FETCH.
- DRAIN:
  - On icache_resp_valid: discard the response, go to FETCH.
  - On rob_flush: pc <= rob_flush_pc, stay in DRAIN. If the flush and a response arrive in the same cycle, go to FETCH with the new pc.
- ISSUE:
  - rob_flush: pc <= rob_flush_pc, go to FETCH, nothing enqueued.
  - Else, if !iq_full, the entry transfers: pc <= pred_pc_next, go to FETCH.
  - Else hold. All iq outputs stay stable.
- icache contract:
  - The cache responds exactly once per request.
  - A high icache_req_valid in the cycle after a response cycle is a new request.
- rdy=0: no register changes and no handshake completes. The cache and queue are frozen under the same rdy.
- Address arithmetic is 32-bit modulo 2^32. The unit does no alignment checking.

## Timing
- Reset:
  - pc=RESET_PC, state=FETCH, ins_reg=0.
  - In the reset cycle all outputs are 0 except icache_req_addr=RESET_PC.
  - icache_req_valid=1 from the first cycle after rst deasserts.
- Response in cycle t → iq_valid=1 in t+1. With iq_full=0 the entry transfers at the end of t+1, and the next request (pred_pc_next) is on the bus in t+2.
- Peak throughput: one instruction per (cache latency + 2) cycles.
- A flush takes effect at the next edge. A new request appears the cycle after the flush, or after the stale response if one was outstanding.
- rst mid-operation overrides everything, including an outstanding request. The cache is reset by the same rst.

## Configuration
- JALR_STALL_EN defined:
  - In ISSUE, when ins_reg[6:0]==7'b1100111 and the entry transfers, go to WAIT_JALR instead of FETCH.
  - WAIT_JALR: icache_req_valid=0 and iq_valid=0. Leave only on rob_flush: pc <= rob_flush_pc, go to FETCH.
  - The ROB always issues rob_flush with the target when a JALR commits.
- Undefined: JALR is handled like any instruction. pc <= pred_pc_next (= pc+4), and a wrong path is recovered by a normal flush. The WAIT_JALR state does not exist.

## Test plan
- Reset, RESET_PC=0, cache latency 2, word 0x00100093, pred_pc_next=4, iq_full=0 → req addr 0 in cycle 1; iq_valid with iq_pc=0, iq_ins=0x00100093 three cycles after the request; next req addr 0x4.
- beq at 0x8, pred_jump=1, pred_pc_next=0x18 → iq_pred_jump=1, iq_pc=0x8; next req addr 0x18.
- iq_full=1 for 5 cycles during ISSUE → iq_valid, iq_pc and iq_ins stable; exactly one transfer after iq_full drops; no icache request during the stall.
- rob_flush to 0x100 one cycle after a request at 0x20 (cache latency 3) → req stays 0x20 until the response; response not enqueued; then req 0x100; first iq_pc=0x100.
- rob_flush to 0x40 while in ISSUE with iq_full=0 → iq_valid=0 that cycle, no enqueue, next req addr 0x40.
- JALR 0x000080E7 at 0x10 with JALR_STALL_EN → enqueued, then no requests for 10 cycles; rob_flush 0x200 → req 0x200 next cycle. Without the macro → req 0x14 immediately.
